// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - three-channel push-button synchroniser/debouncer with serial-bit strobe merge.
// Optional auto-repeat on the data buttons is compiled in with `define BUTTON_AUTOREPEAT_EN.

module button_channel #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter bit REPEAT_EN       = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HELD   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    // The count includes the sample that moves the FSM out of IDLE/HELD,
    // so the terminal value is one less than the required stable run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             press;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rep_q, rep_d;
    logic              repeat_hit;
    logic [HOLD_W-1:0] hold_inc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            hold_q  <= '0;
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
`ifdef BUTTON_AUTOREPEAT_EN
            hold_q  <= hold_d;
            rep_q   <= rep_d;
`endif
        end
    end

    always_comb begin
        s1_d    = (ACTIVE_LOW != 0) ? ~raw : raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press   = 1'b0;

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    if (CNT_LAST == '0) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press   = 1'b1;
                    end else begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    if (CNT_LAST == '0) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                    end else begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BUTTON_AUTOREPEAT_EN
    // Hold timer only advances while the debounced key stays in HELD;
    // any other state drops it back to zero and re-arms the long first delay.
    always_comb begin
        hold_d     = '0;
        rep_d      = 1'b0;
        repeat_hit = 1'b0;
        hold_inc   = hold_q + HOLD_ONE;
        if (REPEAT_EN && (state_q == HELD) && s2_q) begin
            hold_d = hold_inc;
            rep_d  = rep_q;
            if (!rep_q && (hold_inc == HOLD_DELAY)) begin
                repeat_hit = 1'b1;
                hold_d     = '0;
                rep_d      = 1'b1;
            end else if (rep_q && (hold_inc == HOLD_PERIOD)) begin
                repeat_hit = 1'b1;
                hold_d     = '0;
            end
        end
        pulse_d = press | repeat_hit;
    end
`else
    always_comb begin
        pulse_d = press;
    end
`endif

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic but0_raw,
    input  logic but1_raw,
    input  logic start_raw,
    output logic but0_level,
    output logic but1_level,
    output logic start_level,
    output logic but0_pulse,
    output logic but1_pulse,
    output logic start_pulse,
    output logic bit_valid,
    output logic bit_value,
    output logic conflict
);

`ifdef BUTTON_AUTOREPEAT_EN
    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_but0 (
        .clk(clk), .rst(rst), .raw(but0_raw), .level(but0_level), .pulse(but0_pulse)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_but1 (
        .clk(clk), .rst(rst), .raw(but1_raw), .level(but1_level), .pulse(but1_pulse)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
    ) u_start (
        .clk(clk), .rst(rst), .raw(start_raw), .level(start_level), .pulse(start_pulse)
    );
`else
    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW)
    ) u_but0 (
        .clk(clk), .rst(rst), .raw(but0_raw), .level(but0_level), .pulse(but0_pulse)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW)
    ) u_but1 (
        .clk(clk), .rst(rst), .raw(but1_raw), .level(but1_level), .pulse(but1_pulse)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW)
    ) u_start (
        .clk(clk), .rst(rst), .raw(start_raw), .level(start_level), .pulse(start_pulse)
    );
`endif

    // Two simultaneous data presses are ambiguous, so neither becomes a bit.
    assign bit_valid = but0_pulse ^ but1_pulse;
    assign bit_value = but1_pulse;
    assign conflict  = but0_pulse & but1_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and randomized check of button_conditioner against a sample-window model.

module tb_button_conditioner;

    localparam int D  = 4;
    localparam int AL = 1;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic but0_raw = 1'b1;
    logic but1_raw = 1'b1;
    logic start_raw = 1'b1;
    logic but0_level, but1_level, start_level;
    logic but0_pulse, but1_pulse, start_pulse;
    logic bit_valid, bit_value, conflict;

    always #5 clk = ~clk;

`ifdef BUTTON_AUTOREPEAT_EN
    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(AL),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
`else
    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(AL)
    ) dut (
`endif
        .clk(clk), .rst(rst),
        .but0_raw(but0_raw), .but1_raw(but1_raw), .start_raw(start_raw),
        .but0_level(but0_level), .but1_level(but1_level), .start_level(start_level),
        .but0_pulse(but0_pulse), .but1_pulse(but1_pulse), .start_pulse(start_pulse),
        .bit_valid(bit_valid), .bit_value(bit_value), .conflict(conflict)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: a channel's level flips once the last D synchronised samples
    // (each pad sample reaches the FSM two edges after it is taken) all differ from it.
    bit hist [3][$];
    bit lvl_m [3];
    bit pul_m [3];
    int anchor [3];
    int edge_n = 0;

    int pcount [3];
    int pedge [3];
    int vcount, ccount, combo;

    task automatic clear_counts();
        for (int c = 0; c < 3; c++) begin
            pcount[c] = 0;
            pedge[c]  = -1;
        end
        vcount = 0;
        ccount = 0;
        combo  = 0;
    endtask

    task automatic tick();
        bit p [3];
        @(posedge clk);
        edge_n++;
        p[0] = (AL != 0) ? ~but0_raw : but0_raw;
        p[1] = (AL != 0) ? ~but1_raw : but1_raw;
        p[2] = (AL != 0) ? ~start_raw : start_raw;
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                hist[c].delete();
                lvl_m[c]  = 1'b0;
                pul_m[c]  = 1'b0;
                anchor[c] = -1;
            end else begin
                bit all_diff;
                bit s2;
                int sz;
                sz       = hist[c].size();
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    int idx;
                    bit v;
                    idx = sz - 2 - j;
                    v   = (idx >= 0) ? hist[c][idx] : 1'b0;
                    if (v == lvl_m[c]) all_diff = 1'b0;
                end
                s2 = (sz >= 2) ? hist[c][sz-2] : 1'b0;
                pul_m[c] = 1'b0;
                if (all_diff) begin
                    lvl_m[c]  = ~lvl_m[c];
                    pul_m[c]  = lvl_m[c];
                    anchor[c] = lvl_m[c] ? edge_n : -1;
                end
`ifdef BUTTON_AUTOREPEAT_EN
                else if (c < 2 && lvl_m[c]) begin
                    if (!s2) anchor[c] = -1;
                    else if (anchor[c] < 0) anchor[c] = edge_n;
                    else begin
                        int age;
                        age = edge_n - anchor[c];
                        if (age == RD || (age > RD && ((age - RD) % RP) == 0)) pul_m[c] = 1'b1;
                    end
                end
`else
                else if (!s2) anchor[c] = -1;
`endif
                hist[c].push_back(p[c]);
                if (hist[c].size() > D + 2) void'(hist[c].pop_front());
            end
        end
        #1;
        check_eq("but0_level", but0_level, lvl_m[0]);
        check_eq("but1_level", but1_level, lvl_m[1]);
        check_eq("start_level", start_level, lvl_m[2]);
        check_eq("but0_pulse", but0_pulse, pul_m[0]);
        check_eq("but1_pulse", but1_pulse, pul_m[1]);
        check_eq("start_pulse", start_pulse, pul_m[2]);
        check_eq("bit_valid", bit_valid, pul_m[0] ^ pul_m[1]);
        check_eq("conflict", conflict, pul_m[0] & pul_m[1]);
        if (pul_m[0] ^ pul_m[1]) check_eq("bit_value", bit_value, pul_m[1]);
        if (but0_pulse === 1'b1) begin pcount[0]++; pedge[0] = edge_n; end
        if (but1_pulse === 1'b1) begin pcount[1]++; pedge[1] = edge_n; end
        if (start_pulse === 1'b1) begin pcount[2]++; pedge[2] = edge_n; end
        if (bit_valid === 1'b1) vcount++;
        if (conflict === 1'b1) ccount++;
        if (start_pulse === 1'b1 && bit_valid === 1'b1 && bit_value === 1'b0 && conflict === 1'b0) combo++;
    endtask

    task automatic drive(input bit b0, input bit b1, input bit st, input int n);
        but0_raw  = (AL != 0) ? ~b0 : b0;
        but1_raw  = (AL != 0) ? ~b1 : b1;
        start_raw = (AL != 0) ? ~st : st;
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe;
        bit r0, r1, rs;
        clear_counts();
        for (int c = 0; c < 3; c++) anchor[c] = -1;

        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3);
        check_eq("reset_levels", {but0_level, but1_level, start_level}, 0);
        check_eq("reset_strobes", {but0_pulse, but1_pulse, start_pulse, bit_valid, bit_value, conflict}, 0);
        rst = 1'b0;
        drive(0, 0, 0, 10);

        // clean press on but1
        clear_counts();
        pe = edge_n + 1;
        drive(0, 1, 0, 20);
        drive(0, 0, 0, 10);
        check_eq("clean_pulse_count", pcount[1], 1);
        check_eq("clean_latency", pedge[1] - pe, D + 1);
        check_eq("clean_valid_count", vcount, 1);

        // bounce on but0
        clear_counts();
        drive(1, 0, 0, 3);
        drive(0, 0, 0, 1);
        pe = edge_n + 1;
        drive(1, 0, 0, 10);
        drive(0, 0, 0, 10);
        check_eq("bounce_pulse_count", pcount[0], 1);
        check_eq("bounce_latency", pedge[0] - pe, D + 1);

        // simultaneous data presses
        clear_counts();
        drive(1, 1, 0, 12);
        drive(0, 0, 0, 10);
        check_eq("simul_conflict_count", ccount, 1);
        check_eq("simul_valid_count", vcount, 0);

        // reset mid-count with start held
        clear_counts();
        drive(0, 0, 1, 3);
        rst = 1'b1;
        drive(0, 0, 1, 2);
        check_eq("rst_no_pulse", pcount[2], 0);
        rst = 1'b0;
        pe = edge_n + 1;
        drive(0, 0, 1, 10);
        drive(0, 0, 0, 10);
        check_eq("rst_start_count", pcount[2], 1);
        check_eq("rst_start_latency", pedge[2] - pe, D + 1);

        // start and bit-0 accepted together
        clear_counts();
        drive(1, 0, 1, 10);
        drive(0, 0, 0, 10);
        check_eq("start_data_combo", combo, 1);
        check_eq("start_data_conflict", ccount, 0);

        // long hold on but0
        clear_counts();
        drive(1, 0, 0, D + 2 + 60);
        drive(0, 0, 0, 10);
`ifdef BUTTON_AUTOREPEAT_EN
        check_eq("hold_pulse_count", pcount[0], 7);
`else
        check_eq("hold_pulse_count", pcount[0], 1);
`endif

        // randomized toggling with occasional resets
        r0 = 1'b0; r1 = 1'b0; rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) r0 = ~r0;
            if ($urandom_range(0, 5) == 0) r1 = ~r1;
            if ($urandom_range(0, 5) == 0) rs = ~rs;
            rst = ($urandom_range(0, 299) == 0);
            drive(r0, r1, rs, 1);
        end
        rst = 1'b0;
        drive(0, 0, 0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
